// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Optional 8E1 framing is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Rounded clock divider that yields one oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int rate;
    rate = baud * os;
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through receive buffer with occupancy count and overrun pulse.
// Occupancy ranges 0..DEPTH; pointers wrap modulo DEPTH (DEPTH is a power of two).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = valid && ready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; an emptied buffer is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  assign data_out = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a FWFT byte buffer.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          uart_rxd,
  output logic [UART_DATA_W-1:0]        rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV     = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(UART_DATA_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  FULL_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(UART_DATA_W - 1);

  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $error("OVERSAMPLE must be even and at least 8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  // Input synchronizer; idles high so reset never fakes a start edge.
  logic sync1;
  logic rxs;
  logic rxs_prev;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the flop chain a true two-stage shift.
      sync1    <= uart_rxd;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  rx_state_t               state;
  rx_state_t               state_d;
  logic [OS_W-1:0]         samp_cnt;
  logic [OS_W-1:0]         samp_d;
  logic [BIT_W-1:0]        bit_cnt;
  logic [BIT_W-1:0]        bit_d;
  logic [UART_DATA_W-1:0]  shift;
  logic [UART_DATA_W-1:0]  shift_d;
  logic                    frame_err_d;
  logic                    push;
  logic                    start_edge;
  logic [DIV_W-1:0]        tick_cnt;
  logic                    tick;
`ifdef UART_RX_PARITY_EN
  logic                    par_bad;
  logic                    par_bad_d;
  logic                    parity_err_d;
`endif

  assign start_edge = (state == IDLE) && rxs_prev && !rxs;
  assign tick       = (tick_cnt == DIV_LAST);

  // Free-running divider, re-phased on a start edge so samples land mid-bit.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || start_edge) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      samp_cnt   <= samp_d;
      bit_cnt    <= bit_d;
      shift      <= shift_d;
      frame_err  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_d;
      parity_err <= parity_err_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_d     = state;
    samp_d      = samp_cnt;
    bit_d       = bit_cnt;
    shift_d     = shift;
    frame_err_d = 1'b0;
    push        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad;
    parity_err_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          samp_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (samp_cnt == HALF_LAST) begin
            samp_d  = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            samp_d = samp_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_cnt == FULL_LAST) begin
            samp_d  = '0;
            shift_d = {rxs, shift[UART_DATA_W-1:1]};
            bit_d   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            samp_d = samp_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (samp_cnt == FULL_LAST) begin
            samp_d       = '0;
            par_bad_d    = rxs ^ (^shift);
            parity_err_d = rxs ^ (^shift);
            state_d      = STOP;
          end else begin
            samp_d = samp_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (samp_cnt == FULL_LAST) begin
            samp_d = '0;
            if (rxs) begin
`ifdef UART_RX_PARITY_EN
              push = !par_bad;
`else
              push = 1'b1;
`endif
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end else begin
            samp_d = samp_cnt + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .push     (push),
    .data_in  (shift),
    .ready    (rx_ready),
    .data_out (rx_data),
    .valid    (rx_valid),
    .full     (),
    .count    (fifo_count),
    .overrun  (overrun)
  );

endmodule
